// File: rtl/multicore_dispatch_unit.sv
// Purpose : in-order dispatch of ALU requests to NUM_CORES ALU cores plus one LFSR "random" core.
// Latency : request accepted at edge k into an idle unit -> result valid after edge k+1; 1 result/cycle.
// Backpressure: out_ready low holds the result register, FIFO fills, then in_ready drops.
//
// Ports:
//   clk, rst_n                         clock, async active-low reset
//   in_valid/in_ready + in_core_id/in_op/in_op1/in_op2   request front end
//   out_valid/out_ready + out_core_id/out_data/out_carry/out_err   result port
//   rd_core_id -> rd_data              combinational readback of a core's last result
//   fifo_count                         input FIFO occupancy

// Generic single-clock FIFO used by the dispatch front end.
// Latency: push visible at pop_dat the cycle after the push edge; pop_dat is head-of-queue (show-ahead).
// Backpressure: caller must not push while full nor pop while empty.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_dat,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_dat,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  // DEPTH is a power of two, so pointer overflow is the modulo wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: entries are only read once the count says they are valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_dat;
  end

  assign pop_dat = mem[rd_ptr];
  assign full    = (count == DEPTH_C);
  assign empty   = (count == '0);
endmodule

module multicore_dispatch_unit #(
  parameter int              NUM_CORES  = 8,
  parameter int              DATA_W     = 8,
  parameter int              FIFO_DEPTH = 4,
  parameter logic [15:0]     LFSR_SEED  = 16'hACE1,
  parameter int              ID_W       = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [ID_W-1:0]               in_core_id,
  input  logic [2:0]                    in_op,
  input  logic [DATA_W-1:0]             in_op1,
  input  logic [DATA_W-1:0]             in_op2,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [ID_W-1:0]               out_core_id,
  output logic [DATA_W-1:0]             out_data,
  output logic                          out_carry,
  output logic                          out_err,
  input  logic [ID_W-1:0]               rd_core_id,
  output logic [DATA_W-1:0]             rd_data,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
  localparam logic [ID_W-1:0] SPECIAL_ID = ID_W'(NUM_CORES);

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_AND = 3'd1;
  localparam logic [2:0] OP_OR  = 3'd2;
  localparam logic [2:0] OP_NOT = 3'd3;
  localparam logic [2:0] OP_SUB = 3'd4;
  localparam logic [2:0] OP_XOR = 3'd5;

  typedef struct packed {
    logic [ID_W-1:0]   core_id;
    logic [2:0]        op;
    logic [DATA_W-1:0] op1;
    logic [DATA_W-1:0] op2;
  } req_t;

  // ---------------------------------------------------------------------------
  // Input FIFO
  // ---------------------------------------------------------------------------
  req_t in_req;
  req_t head;
  logic fifo_full;
  logic fifo_empty;
  logic push;
  logic issue;

  assign in_req   = '{core_id: in_core_id, op: in_op, op1: in_op1, op2: in_op2};
  assign in_ready = !fifo_full;
  assign push     = in_valid && in_ready;
  // Pop whenever the result register is free or being drained this cycle.
  assign issue    = !fifo_empty && (!out_valid || out_ready);

  sync_fifo #(
    .WIDTH (($bits(req_t))),
    .DEPTH (FIFO_DEPTH)
  ) u_req_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .push_dat (in_req),
    .pop      (issue),
    .pop_dat  (head),
    .count    (fifo_count),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  // ---------------------------------------------------------------------------
  // Special core LFSR: free-running from reset, independent of traffic
  // ---------------------------------------------------------------------------
  logic [15:0] lfsr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr <= LFSR_SEED;
    else        lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end

  // ---------------------------------------------------------------------------
  // Execute the head entry (combinational, captured at the pop edge)
  // ---------------------------------------------------------------------------
  logic [DATA_W:0]   sum_ext;
  logic [DATA_W:0]   diff_ext;
  logic [DATA_W-1:0] res_data;
  logic              res_carry;
  logic              res_err;
  logic              res_wr;

  assign sum_ext  = {1'b0, head.op1} + {1'b0, head.op2};
  // The top bit of the extended difference is the borrow, i.e. op1 < op2.
  assign diff_ext = {1'b0, head.op1} - {1'b0, head.op2};

  always_comb begin
    res_data  = '0;
    res_carry = 1'b0;
    res_err   = 1'b0;
    res_wr    = 1'b0;
    if (head.core_id > SPECIAL_ID) begin
      res_err = 1'b1;
    end else if (head.core_id == SPECIAL_ID) begin
      // The special core ignores op and operands, so reserved ops are not an error here.
      res_data = {{(DATA_W-1){1'b0}}, lfsr[0]};
      res_wr   = 1'b1;
    end else begin
      res_wr = 1'b1;
      case (head.op)
        OP_ADD: begin
          res_data  = sum_ext[DATA_W-1:0];
          res_carry = sum_ext[DATA_W];
        end
        OP_AND: res_data = head.op1 & head.op2;
        OP_OR:  res_data = head.op1 | head.op2;
        OP_NOT: res_data = ~head.op1;
        OP_SUB: begin
          res_data  = diff_ext[DATA_W-1:0];
          res_carry = diff_ext[DATA_W];
        end
        OP_XOR: res_data = head.op1 ^ head.op2;
        default: begin
          res_err = 1'b1;
          res_wr  = 1'b0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Result register / output port
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid   <= 1'b0;
      out_core_id <= '0;
      out_data    <= '0;
      out_carry   <= 1'b0;
      out_err     <= 1'b0;
    end else if (issue) begin
      out_valid   <= 1'b1;
      out_core_id <= head.core_id;
      out_data    <= res_data;
      out_carry   <= res_carry;
      out_err     <= res_err;
    end else if (out_ready) begin
      out_valid   <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Per-core last-result registers (index NUM_CORES is the special core)
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] core_res [NUM_CORES+1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i <= NUM_CORES; i++) core_res[i] <= '0;
    end else if (issue && res_wr) begin
      for (int i = 0; i <= NUM_CORES; i++) begin
        if (head.core_id == ID_W'(i)) core_res[i] <= res_data;
      end
    end
  end

  // Out-of-range selects match no entry and read back as zero.
  always_comb begin
    rd_data = '0;
    for (int i = 0; i <= NUM_CORES; i++) begin
      if (rd_core_id == ID_W'(i)) rd_data = core_res[i];
    end
  end
endmodule

// File: doc/multicore_dispatch_unit.md
Name: multicore_dispatch_unit

Overview:
Parametrised successor of the fixed eight-core ALU processor. It accepts operation requests through a valid/ready front end and buffers them in an input FIFO. Requests issue in order, one per cycle, to NUM_CORES ALU cores plus one special random core, and results return through a valid/ready result port with core ID and error flag. Each core's last result is held in a register and is readable at any time; the special core uses a deterministic LFSR in place of simulation-only randomness.

Parameters:
NUM_CORES, 8, number of ALU cores; special core ID = NUM_CORES
DATA_W, 8, operand/result width
FIFO_DEPTH, 4, input FIFO entries (power of two, >=2)
LFSR_SEED, 16'hACE1, special-core LFSR reset value (nonzero)
ID_W, 4, core ID width; must satisfy 2^ID_W > NUM_CORES

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  request valid
in_ready  output  1  request accepted when in_valid & in_ready
in_core_id  input  ID_W  target core
in_op  input  3  0 ADD, 1 AND, 2 OR, 3 NOT(op1), 4 SUB, 5 XOR, 6-7 reserved
in_op1  input  DATA_W  operand 1
in_op2  input  DATA_W  operand 2
out_valid  output  1  result valid
out_ready  input  1  result consumed when out_valid & out_ready
out_core_id  output  ID_W  core that produced the result
out_data  output  DATA_W  result
out_carry  output  1  ADD carry-out / SUB borrow, else 0
out_err  output  1  invalid core ID or reserved op
rd_core_id  input  ID_W  readback select
rd_data  output  DATA_W  last result of selected core (combinational)
fifo_count  output  clog2(FIFO_DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (rst_n low, asynchronous): FIFO empty, fifo_count=0, out_valid=0, out_core_id/out_data/out_carry/out_err=0, all per-core result registers=0, LFSR=LFSR_SEED. in_ready=1 as soon as reset releases. Reset mid-operation discards all queued and pending results.
- FIFO: in_ready = (fifo_count != FIFO_DEPTH). A push while full is not possible. Push and pop in the same cycle leave the count unchanged. Pointers wrap modulo FIFO_DEPTH.
- Issue: the head entry pops when FIFO is non-empty and (out_valid==0 or out_ready==1).
- Issue latency: the popped entry's result is registered at the same edge, so out_valid rises the cycle after the pop. A request accepted at edge k into an idle unit gives out_valid=1 after edge k+1.
- Output register: out_* hold stable while out_valid & !out_ready. out_valid clears on a handshake when no new pop occurs at that edge.
- Throughput: 1 result/cycle with out_ready held high.
- ALU cores (ID < NUM_CORES): results are computed modulo 2^DATA_W.
  - ADD: out_carry = bit DATA_W of op1+op2.
  - SUB: op1-op2; out_carry=1 when op1<op2.
  - NOT ignores op2.
  - The result is also written to that core's result register at issue.
- Special core (ID == NUM_CORES): out_data = {0..., lfsr[0]}, op and operands ignored, out_carry=0. The core's result register updates.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11; feedback = l[15]^l[13]^l[12]^l[10]; new l = {l[14:0], feedback}. Advances every cycle after reset, independent of traffic.
- Error: ID > NUM_CORES or op 6/7 gives out_data=0, out_carry=0, out_err=1, with no result-register update. out_core_id echoes the requested ID.
- Readback: rd_data = result register of rd_core_id. It returns 0 for rd_core_id > NUM_CORES. A same-cycle write is visible after the edge.

Test Plan:
1. Reset, then ID=2 ADD 8'hF0+8'h20 with out_ready=1 -> out_valid one cycle after issue; out_data=8'h10, out_carry=1, out_core_id=2; rd_core_id=2 returns 8'h10.
2. Hold out_ready=0 and push 6 requests -> in_ready drops after the 5th acceptance (4 in FIFO + 1 in output register), fifo_count=4, out_* stable. Release out_ready -> results drain in order at 1/cycle.
3. ID=8 repeated 16 times, LFSR_SEED=16'hACE1 -> out_data bit 0 matches the reference LFSR model sequence cycle by cycle, upper bits 0.
4. ID=9 ADD, then ID=1 op=7 -> both out_err=1, out_data=0; result registers 9 and 1 unchanged (rd_data=0 after reset).
5. SUB 8'h05-8'h07 on ID=0 -> out_data=8'hFE, out_carry=1. NOT 8'h5A on ID=7 -> 8'hA5.
6. Assert rst_n low with 3 queued requests and out_valid=1 -> out_valid=0 and fifo_count=0 immediately; the LFSR reloads the seed.
